reward_pkt_builder: RTL and testbench



---
 rtl/eer_pkt_pkg.sv | 54 +++++
 rtl/reward_timer.sv | 36 +++
 rtl/reward_pkt_builder.sv | 217 +++++++++++++++++++++
 tb/tb_reward_pkt_builder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/eer_pkt_pkg.sv
// rtl/eer_pkt_pkg.sv - shared packet types, word layout and flag priority for the EER-RL reward packer
package eer_pkt_pkg;

  typedef enum logic [2:0] {
    PKT_HB      = 3'b000,
    PKT_CHE     = 3'b001,
    PKT_INV     = 3'b010,
    PKT_MR      = 3'b011,
    PKT_CHT     = 3'b100,
    PKT_DATA    = 3'b101,
    PKT_SOS     = 3'b110,
    PKT_INVALID = 3'b111
  } pkt_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } fsm_state_e;

  localparam int PKT_WORDS = 8;

  localparam int W_TYPE   = 0;
  localparam int W_SRC    = 1;
  localparam int W_DEST   = 2;
  localparam int W_HOPS   = 3;
  localparam int W_QVAL   = 4;
  localparam int W_ENERGY = 5;
  localparam int W_CH     = 6;
  localparam int W_CHHOPS = 7;

  // Flag bit order is the send priority: bit 0 wins.
  localparam int N_FLAGS = 6;
  localparam int F_HB    = 0;
  localparam int F_INV   = 1;
  localparam int F_FWD   = 2;
  localparam int F_CHINV = 3;
  localparam int F_MR    = 4;
  localparam int F_CHT   = 5;

  function automatic logic [N_FLAGS-1:0] pick_highest(input logic [N_FLAGS-1:0] pend);
    logic [N_FLAGS-1:0] onehot;
    onehot = '0;
    for (int i = N_FLAGS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/reward_timer.sv
// rtl/reward_timer.sv - countdown timer with load, cancel and a one-cycle expire strobe on the 1->0 step
module reward_timer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15,
  parameter bit RELOAD  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic cancel,
  output logic expire
);

  localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(TIMEOUT);

  logic [WIDTH-1:0] count;
  logic             running;
  logic             load_ok;

  assign running = (count != '0);
  // Without RELOAD a running countdown ignores further load requests.
  assign load_ok = load && (RELOAD || !running);

  always_ff @(posedge clk) begin
    if (rst || cancel) begin
      count <= '0;
    end else if (load_ok) begin
      count <= LOAD_VAL;
    end else if (running) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = (count == WIDTH'(1)) && !cancel && !load_ok;

endmodule

// File: rtl/reward_pkt_builder.sv
// rtl/reward_pkt_builder.sv - queues EER-RL transmit obligations as flags and streams each as an 8-word packet
module reward_pkt_builder
  import eer_pkt_pkg::*;
#(
  parameter int                    WORD_WIDTH  = 16,
  parameter int                    MAX_CH_HOPS = 4,
  parameter int                    MR_TIMEOUT  = 15,
  parameter int                    CHT_TIMEOUT = 15,
  parameter logic [WORD_WIDTH-1:0] SINK_ID     = '0,
  parameter logic [WORD_WIDTH-1:0] BCAST_ID    = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2:0]            fPacketType,
  input  logic                  iAmDestination,
  input  logic [WORD_WIDTH-1:0] rxCHID,
  input  logic [WORD_WIDTH-1:0] rxCHHops,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] hopsFromSink,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic                  role,
  input  logic                  low_E,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsFromCH,
  input  logic [WORD_WIDTH-1:0] nextHop,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  reward_done,
  output logic [7:0]            drop_cnt
);

  localparam logic [WORD_WIDTH-1:0] MAX_HOPS_W = WORD_WIDTH'(MAX_CH_HOPS);
  localparam logic [2:0]            LAST_IDX   = 3'(PKT_WORDS - 1);

  pkt_type_e             rx_type;
  fsm_state_e            state, state_next;
  logic [N_FLAGS-1:0]    flags, set_vec, clear_vec, sel;
  logic                  hb_lock, role_q, fwd_sos, sent_chinv;
  logic [WORD_WIDTH-1:0] inv_ch, inv_hops;
  logic [2:0]            idx;
  logic [WORD_WIDTH-1:0] bank       [PKT_WORDS];
  logic [WORD_WIDTH-1:0] load_words [PKT_WORDS];

  logic hb_trig, inv_valid, fwd_trig, role_rise, role_chg;
  logic hb_held, inv_held, fwd_held, hb_drop, fwd_drop;
  logic handshake, last_hs, mr_expire, cht_expire;

  assign rx_type   = pkt_type_e'(fPacketType);
  assign hb_trig   = en && (rx_type == PKT_HB);
  assign inv_valid = en && (rx_type == PKT_INV) && (rxCHHops < MAX_HOPS_W) && !role;
  assign fwd_trig  = en && iAmDestination && ((rx_type == PKT_DATA) || (rx_type == PKT_SOS));
  assign role_rise = role && !role_q;
  assign role_chg  = role != role_q;

  assign sel       = pick_highest(flags);
  assign clear_vec = (state == S_LOAD) ? sel : '0;

  // "Held" means still pending after this cycle regardless of any new trigger;
  // a flag cleared at LOAD this cycle counts as free so the new event re-arms it.
  assign hb_held  = flags[F_HB]  && !clear_vec[F_HB];
  assign inv_held = flags[F_INV] && !clear_vec[F_INV];
  assign fwd_held = flags[F_FWD] && !clear_vec[F_FWD];
  assign hb_drop  = hb_trig && hb_lock && !hb_held;
  assign fwd_drop = fwd_trig && fwd_held;

  assign handshake = (state == S_SEND) && tx_ready;
  assign last_hs   = handshake && (idx == LAST_IDX);

  always_comb begin
    set_vec          = '0;
    set_vec[F_HB]    = hb_trig && !hb_drop;
    set_vec[F_INV]   = inv_valid;
    set_vec[F_FWD]   = fwd_trig && !fwd_drop;
    set_vec[F_CHINV] = role_rise;
    set_vec[F_MR]    = mr_expire;
    set_vec[F_CHT]   = cht_expire;
  end

  reward_timer #(
    .WIDTH   (WORD_WIDTH),
    .TIMEOUT (MR_TIMEOUT),
    .RELOAD  (1'b0)
  ) u_mr_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (inv_valid),
    .cancel (role_chg),
    .expire (mr_expire)
  );

  reward_timer #(
    .WIDTH   (WORD_WIDTH),
    .TIMEOUT (CHT_TIMEOUT),
    .RELOAD  (1'b1)
  ) u_cht_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (last_hs && sent_chinv),
    .cancel (role_chg),
    .expire (cht_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      flags    <= '0;
      hb_lock  <= 1'b0;
      role_q   <= 1'b0;
      fwd_sos  <= 1'b0;
      inv_ch   <= '0;
      inv_hops <= '0;
      drop_cnt <= '0;
    end else begin
      flags  <= (flags & ~clear_vec) | set_vec;
      role_q <= role;
      if (en && (rx_type == PKT_DATA)) begin
        hb_lock <= 1'b0;
      end else if (hb_trig) begin
        hb_lock <= 1'b1;
      end
      // A merged INV keeps the CH fields of the trigger that first armed it.
      if (inv_valid && !inv_held) begin
        inv_ch   <= rxCHID;
        inv_hops <= rxCHHops + WORD_WIDTH'(1);
      end
      if (set_vec[F_FWD]) begin
        fwd_sos <= (rx_type == PKT_SOS) || low_E;
      end
      if ((hb_drop || fwd_drop) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    logic [2:0]            ptype;
    logic [WORD_WIDTH-1:0] dest, pkt_ch, pkt_hops;
    ptype    = PKT_HB;
    dest     = BCAST_ID;
    pkt_ch   = chosenCH;
    pkt_hops = hopsFromCH;
    if (sel[F_INV]) begin
      ptype    = PKT_INV;
      pkt_ch   = inv_ch;
      pkt_hops = inv_hops;
    end else if (sel[F_FWD]) begin
      ptype = fwd_sos ? PKT_SOS : PKT_DATA;
      dest  = (hopsFromSink == WORD_WIDTH'(1)) ? SINK_ID : nextHop;
    end else if (sel[F_CHINV]) begin
      ptype    = PKT_INV;
      pkt_ch   = myNodeID;
      pkt_hops = '0;
    end else if (sel[F_MR]) begin
      ptype = PKT_MR;
      dest  = chosenCH;
    end else if (sel[F_CHT]) begin
      ptype    = PKT_CHT;
      pkt_ch   = myNodeID;
      pkt_hops = '0;
    end
    load_words[W_TYPE]   = {{(WORD_WIDTH-3){1'b0}}, ptype};
    load_words[W_SRC]    = myNodeID;
    load_words[W_DEST]   = dest;
    load_words[W_HOPS]   = hopsFromSink;
    load_words[W_QVAL]   = myQValue;
    load_words[W_ENERGY] = myEnergy;
    load_words[W_CH]     = pkt_ch;
    load_words[W_CHHOPS] = pkt_hops;
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      for (int i = 0; i < PKT_WORDS; i++) begin
        bank[i] <= load_words[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      sent_chinv <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_LOAD) begin
        idx        <= '0;
        sent_chinv <= sel[F_CHINV];
      end else if (handshake) begin
        idx <= idx + 3'd1;
      end
    end
  end

  // DONE goes straight to LOAD when work is queued, giving a 2-cycle inter-packet gap.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if ((flags | set_vec) != '0) state_next = S_LOAD;
      S_LOAD:  state_next = S_SEND;
      S_SEND:  if (last_hs) state_next = S_DONE;
      S_DONE:  state_next = ((flags | set_vec) != '0) ? S_LOAD : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign tx_valid    = (state == S_SEND);
  assign tx_last     = tx_valid && (idx == LAST_IDX);
  assign tx_data     = tx_valid ? bank[idx] : '0;
  assign busy        = (state != S_IDLE);
  assign reward_done = (state == S_DONE);

endmodule

// File: tb/tb_reward_pkt_builder.sv
// tb/tb_reward_pkt_builder.sv - directed self-checking bench for reward_pkt_builder
module tb_reward_pkt_builder;

  logic        clk, rst, en, iAmDestination, role, low_E;
  logic [2:0]  fPacketType;
  logic [15:0] rxCHID, rxCHHops, myNodeID, hopsFromSink, myQValue, myEnergy;
  logic [15:0] chosenCH, hopsFromCH, nextHop, tx_data;
  logic        tx_valid, tx_ready, tx_last, busy, reward_done;
  logic [7:0]  drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  reward_pkt_builder dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .fPacketType    (fPacketType),
    .iAmDestination (iAmDestination),
    .rxCHID         (rxCHID),
    .rxCHHops       (rxCHHops),
    .myNodeID       (myNodeID),
    .hopsFromSink   (hopsFromSink),
    .myQValue       (myQValue),
    .myEnergy       (myEnergy),
    .role           (role),
    .low_E          (low_E),
    .chosenCH       (chosenCH),
    .hopsFromCH     (hopsFromCH),
    .nextHop        (nextHop),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_last        (tx_last),
    .busy           (busy),
    .reward_done    (reward_done),
    .drop_cnt       (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0][15:0] mk(input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7);
    return {w7, w6, w5, w4, w3, w2, w1, w0};
  endfunction

  // Called on the cycle word 0 is presented with tx_ready held high.
  task automatic expect_pkt(input string tag, input logic [7:0][15:0] w);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), {31'd0, tx_valid}, 32'd1);
      chk($sformatf("%s_data%0d", tag, i), {16'd0, tx_data}, {16'd0, w[i]});
      chk($sformatf("%s_last%0d", tag, i), {31'd0, tx_last}, (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    chk($sformatf("%s_done", tag), {31'd0, reward_done}, 32'd1);
    tick();
  endtask

  task automatic pulse(input logic [2:0] t, input logic iad, input logic [15:0] chid, input logic [15:0] chh);
    en = 1'b1; fPacketType = t; iAmDestination = iad; rxCHID = chid; rxCHHops = chh;
    tick();
    en = 1'b0; iAmDestination = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fPacketType = 3'd0; iAmDestination = 1'b0;
    rxCHID = 16'd0; rxCHHops = 16'd0; myNodeID = 16'd5; hopsFromSink = 16'd3;
    myQValue = 16'h0AAA; myEnergy = 16'h0BBB; role = 1'b0; low_E = 1'b0;
    chosenCH = 16'd7; hopsFromCH = 16'd2; nextHop = 16'h0011; tx_ready = 1'b1;

    tick(); tick();
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_last", {31'd0, tx_last}, 32'd0);
    chk("rst_data", {16'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, reward_done}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // HB: LOAD at t+1, words at t+2..t+9, done at t+10
    pulse(3'b000, 1'b0, 16'd0, 16'd0);
    chk("hb_load_busy", {31'd0, busy}, 32'd1);
    chk("hb_load_valid", {31'd0, tx_valid}, 32'd0);
    tick();
    expect_pkt("hb1", mk(16'd0, 16'd5, 16'hFFFF, 16'd3, 16'h0AAA, 16'h0BBB, 16'd7, 16'd2));
    chk("hb1_idle", {31'd0, busy}, 32'd0);
    pulse(3'b000, 1'b0, 16'd0, 16'd0);
    chk("hb_locked_drop", {24'd0, drop_cnt}, 32'd1);
    chk("hb_locked_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    chk("hb_locked_novalid", {31'd0, tx_valid}, 32'd0);
    pulse(3'b101, 1'b0, 16'd0, 16'd0);
    chk("data_notdest_busy", {31'd0, busy}, 32'd0);
    pulse(3'b000, 1'b0, 16'd0, 16'd0);
    chk("hb_unlocked_busy", {31'd0, busy}, 32'd1);
    tick();
    expect_pkt("hb2", mk(16'd0, 16'd5, 16'hFFFF, 16'd3, 16'h0AAA, 16'h0BBB, 16'd7, 16'd2));

    // INV ripple then MR: MR flag lands 16 cycles after the INV strobe
    pulse(3'b010, 1'b0, 16'd9, 16'd2);
    tick();
    expect_pkt("inv", mk(16'd2, 16'd5, 16'hFFFF, 16'd3, 16'h0AAA, 16'h0BBB, 16'd9, 16'd3));
    repeat (4) tick();
    chk("mr_not_yet", {31'd0, busy}, 32'd0);
    tick();
    chk("mr_load", {31'd0, busy}, 32'd1);
    tick();
    expect_pkt("mr", mk(16'd3, 16'd5, 16'd7, 16'd3, 16'h0AAA, 16'h0BBB, 16'd7, 16'd2));
    pulse(3'b010, 1'b0, 16'd9, 16'd4);
    chk("inv_maxhops_busy", {31'd0, busy}, 32'd0);
    repeat (20) tick();
    chk("inv_maxhops_nomr", {31'd0, busy}, 32'd0);
    chk("inv_maxhops_drop", {24'd0, drop_cnt}, 32'd1);

    // Role rise -> CHINV; CHT flag 16 cycles after CHINV's last handshake
    role = 1'b1;
    tick();
    chk("chinv_load", {31'd0, busy}, 32'd1);
    tick();
    expect_pkt("chinv", mk(16'd2, 16'd5, 16'hFFFF, 16'd3, 16'h0AAA, 16'h0BBB, 16'd5, 16'd0));
    repeat (13) tick();
    chk("cht_not_yet", {31'd0, busy}, 32'd0);
    tick();
    chk("cht_load", {31'd0, busy}, 32'd1);
    tick();
    expect_pkt("cht", mk(16'd4, 16'd5, 16'hFFFF, 16'd3, 16'h0AAA, 16'h0BBB, 16'd5, 16'd0));
    role = 1'b0;
    repeat (3) tick();
    chk("role_fall_idle", {31'd0, busy}, 32'd0);

    // FWD as SOS to sink; a third Data while the second is pending is dropped
    low_E = 1'b1; hopsFromSink = 16'd1;
    pulse(3'b101, 1'b1, 16'd0, 16'd0);
    chk("fwd_load", {31'd0, busy}, 32'd1);
    pulse(3'b101, 1'b1, 16'd0, 16'd0);
    chk("fwd_w0", {16'd0, tx_data}, 32'd6);
    pulse(3'b101, 1'b1, 16'd0, 16'd0);
    chk("fwd_drop", {24'd0, drop_cnt}, 32'd2);
    chk("fwd_w1", {16'd0, tx_data}, 32'd5);
    repeat (6) tick();
    chk("fwd_last", {31'd0, tx_last}, 32'd1);
    tick();
    chk("fwd_done", {31'd0, reward_done}, 32'd1);
    tick();
    chk("fwd_gap_load", {31'd0, busy}, 32'd1);
    chk("fwd_gap_novalid", {31'd0, tx_valid}, 32'd0);
    tick();
    expect_pkt("fwd2", mk(16'd6, 16'd5, 16'd0, 16'd1, 16'h0AAA, 16'h0BBB, 16'd7, 16'd2));
    chk("fwd2_drop_kept", {24'd0, drop_cnt}, 32'd2);
    low_E = 1'b0; hopsFromSink = 16'd3;

    // Stall: word 0 held 5 cycles while HB and FWD queue up; HB goes first
    tx_ready = 1'b0;
    pulse(3'b101, 1'b1, 16'd0, 16'd0);
    pulse(3'b000, 1'b0, 16'd0, 16'd0);
    pulse(3'b101, 1'b1, 16'd0, 16'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall_valid%0d", k), {31'd0, tx_valid}, 32'd1);
      chk($sformatf("stall_data%0d", k), {16'd0, tx_data}, 32'd5);
      chk($sformatf("stall_last%0d", k), {31'd0, tx_last}, 32'd0);
      tick();
    end
    tx_ready = 1'b1;
    expect_pkt("fwd_stall", mk(16'd5, 16'd5, 16'h0011, 16'd3, 16'h0AAA, 16'h0BBB, 16'd7, 16'd2));
    chk("prio_load1", {31'd0, busy}, 32'd1);
    tick();
    expect_pkt("hb_prio", mk(16'd0, 16'd5, 16'hFFFF, 16'd3, 16'h0AAA, 16'h0BBB, 16'd7, 16'd2));
    chk("prio_load2", {31'd0, busy}, 32'd1);
    tick();
    expect_pkt("fwd_after", mk(16'd5, 16'd5, 16'h0011, 16'd3, 16'h0AAA, 16'h0BBB, 16'd7, 16'd2));

    // rst at word 4 abandons the packet and clears queued INV and MR timer
    pulse(3'b000, 1'b0, 16'd0, 16'd0);
    pulse(3'b010, 1'b0, 16'd9, 16'd1);
    repeat (4) tick();
    chk("rst_w4", {16'd0, tx_data}, 32'h0AAA);
    rst = 1'b1;
    tick();
    chk("midrst_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_drop", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    chk("postrst_flags", {31'd0, busy}, 32'd0);
    repeat (20) tick();
    chk("postrst_timer", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
